// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Opcodes, condition-code reset value and stage-1 control bundle
//          shared by the pipelined ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR = 3'd3;
  localparam logic [OP_W-1:0] OP_SHL = 3'd4;
  localparam logic [OP_W-1:0] OP_SAR = 3'd5;
  localparam logic [OP_W-1:0] OP_RSV = 3'd7;

  // Condition-code reset value, ordered {ZF, SF, OF}.
  localparam logic [2:0] CC_RST = 3'b100;

  // Operand data is width-parametric, so the data-carrying bundle is
  // declared in the top; this is its width-independent control part.
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic            set_cc;
  } op_ctl_t;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module : alu_core
// Brief  : Combinational ALU datapath; shifts exist only with ALU_SHIFT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] r,
  output logic             ovf,
  output logic             illegal
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;

  assign w_sum  = a + b;
  assign w_diff = a - b;

`ifdef ALU_SHIFT_EN
  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] w_shamt;

  // Only the low log2(WIDTH) bits of b form the shift amount.
  assign w_shamt = b[SHW-1:0];
`endif

  always_comb begin
    r       = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_ADD: begin
        r   = w_sum;
        ovf = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        r   = w_diff;
        ovf = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      OP_AND: r = a & b;
      OP_XOR: r = a ^ b;
`ifdef ALU_SHIFT_EN
      OP_SHL: r = a << w_shamt;
      OP_SAR: r = $unsigned($signed(a) >>> w_shamt);
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// Module : alu_pipe
// Brief  : Two-stage valid/ready ALU pipeline with a ZF/SF/OF register.
//          Shift opcodes are enabled by defining ALU_SHIFT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_op,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam int MSB = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_ctl_t          ctl;
  } s1_bundle_t;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_retire;
  logic [OP_W-1:0]  w_in_op;
  s1_bundle_t       w_in_bundle;

  logic [WIDTH-1:0] w_core_r;
  logic             w_core_ovf;
  logic             w_core_ill;

  logic             r_s1_valid;
  s1_bundle_t       r_s1;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_result;
  logic             r_s2_ovf;
  logic             r_s2_ill;
  logic             r_s2_set_cc;

  logic             r_cc_zf;
  logic             r_cc_sf;
  logic             r_cc_of;

  assign w_adv2   = !r_s2_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign w_retire = r_s2_valid && out_ready;

  // Opcodes wider than the defined group map onto a reserved encoding.
  always_comb begin
    w_in_op = in_op[OP_W-1:0];
    if (|(in_op >> OP_W)) begin
      w_in_op = OP_RSV;
    end
  end

  always_comb begin
    w_in_bundle            = '0;
    w_in_bundle.a          = in_a;
    w_in_bundle.b          = in_b;
    w_in_bundle.ctl.op     = w_in_op;
    w_in_bundle.ctl.set_cc = in_set_cc;
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a       (r_s1.a),
    .b       (r_s1.b),
    .op      (r_s1.ctl.op),
    .r       (w_core_r),
    .ovf     (w_core_ovf),
    .illegal (w_core_ill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1        <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_ovf    <= 1'b0;
      r_s2_ill    <= 1'b0;
      r_s2_set_cc <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1 <= w_in_bundle;
        end
      end
      // Stage-2 payload only moves with a real op, so it stays stable on stall.
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_result <= w_core_r;
          r_s2_ovf    <= w_core_ovf;
          r_s2_ill    <= w_core_ill;
          r_s2_set_cc <= r_s1.ctl.set_cc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {r_cc_zf, r_cc_sf, r_cc_of} <= CC_RST;
    end else if (w_retire && r_s2_set_cc && !r_s2_ill) begin
      r_cc_zf <= (r_s2_result == '0);
      r_cc_sf <= r_s2_result[MSB];
      r_cc_of <= r_s2_ovf;
    end
  end

  assign in_ready    = w_adv1;
  assign out_valid   = r_s2_valid;
  assign out_result  = r_s2_result;
  assign out_ovf     = r_s2_ovf;
  assign out_illegal = r_s2_ill;
  assign cc_zf       = r_cc_zf;
  assign cc_sf       = r_cc_sf;
  assign cc_of       = r_cc_of;

endmodule

`default_nettype wire
